// File: rtl/tcspc_pkg.sv
// rtl/tcspc_pkg.sv - shared states, command codes and saturating increment for the histogram memory
package tcspc_pkg;

  // Command encodings driven by the host side
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;
  localparam logic [1:0] CMD_ACCUM = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  // Controller states; DRAIN lets in-flight increments land before CLEAR/READ
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ACCUM = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_CLEAR = 3'd3;
  localparam state_t ST_READ  = 3'd4;

  // Increment that sticks at max_value instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/tcspc_bin_ram.sv
// rtl/tcspc_bin_ram.sv - bin counter array with one write port, async increment read and registered read-out port
module tcspc_bin_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] inc_addr,
  output logic [DW-1:0] inc_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Combinational read feeding the increment stage
  assign inc_data = mem[inc_addr];

  // Single write port shared by the increment pipeline and the clear sweep
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-out port holds its word until the consumer asks for the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tcspc_histogram_mem.sv
// rtl/tcspc_histogram_mem.sv - photon time-correlation histogram with pipelined saturating increments, swept clear and streamed read-out
module tcspc_histogram_mem
  import tcspc_pkg::*;
#(
  parameter int NUM_BINS    = 128,
  parameter int BIN_AW      = $clog2(NUM_BINS),
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             Command,
  input  logic                   hit_valid,
  input  logic [BIN_AW-1:0]      hit_bin,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic [BIN_AW-1:0]      rd_bin,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   overflow,
  output logic                   dropped
);

  localparam logic [BIN_AW-1:0]      LAST_BIN  = BIN_AW'(NUM_BINS - 1);
  localparam logic [31:0]            MAX_WIDE  = 32'((64'd1 << COUNT_WIDTH) - 64'd1);
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = '1;

  state_t                   state;
  logic                     drain_to_read;
  logic [BIN_AW-1:0]        clr_idx;

  logic                     s1_valid;
  logic [BIN_AW-1:0]        s1_bin;
  logic                     s2_valid;
  logic [BIN_AW-1:0]        s2_bin;
  logic [COUNT_WIDTH-1:0]   s2_data;

  logic                     ram_we;
  logic [BIN_AW-1:0]        ram_waddr;
  logic [COUNT_WIDTH-1:0]   ram_wdata;
  logic [COUNT_WIDTH-1:0]   ram_inc_data;
  logic                     ram_rd_en;
  logic [BIN_AW-1:0]        ram_rd_addr;

  logic [COUNT_WIDTH-1:0]   fwd_count;
  logic                     xfer;
  logic                     clear_entry;

  tcspc_bin_ram #(
    .DEPTH (NUM_BINS),
    .AW    (BIN_AW),
    .DW    (COUNT_WIDTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .inc_addr (s1_bin),
    .inc_data (ram_inc_data),
    .rd_en    (ram_rd_en),
    .rd_addr  (ram_rd_addr),
    .rd_data  (rd_data)
  );

  assign xfer     = rd_valid && rd_ready;
  assign rd_last  = rd_valid && (rd_bin == LAST_BIN);
  assign busy     = (state == ST_DRAIN) || (state == ST_CLEAR) || (state == ST_READ);

  // S2 writes at the end of this cycle, so a matching S1 must take S2's value rather than the stale array word
  assign fwd_count = (s2_valid && (s2_bin == s1_bin)) ? s2_data : ram_inc_data;

  // Sticky flags reset on every path into CLEAR
  assign clear_entry = ((state == ST_IDLE) && (Command == CMD_CLEAR)) ||
                       ((state == ST_DRAIN) && !s1_valid && !drain_to_read);

  // Write port owner: the clear sweep while clearing, otherwise the increment pipeline
  always_comb begin
    ram_we    = s2_valid;
    ram_waddr = s2_bin;
    ram_wdata = s2_data;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = '0;
    end
  end

  // Fetch bin 0 on entry, then prefetch the next bin on each accepted word for zero-bubble streaming
  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    if (state == ST_READ) begin
      if (!rd_valid) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = '0;
      end else if (xfer && !rd_last) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = rd_bin + BIN_AW'(1);
      end
    end
  end

  // Two-stage increment: S1 captures accepted hits, S2 holds the saturated value being written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= hit_valid && (state == ST_ACCUM);
      s1_bin   <= hit_bin;
      s2_valid <= s1_valid;
      s2_bin   <= s1_bin;
      s2_data  <= COUNT_WIDTH'(sat_inc(32'(fwd_count), MAX_WIDE));
    end
  end

  // Sticky overflow/dropped status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      dropped  <= 1'b0;
    end else if (clear_entry) begin
      overflow <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      if (s1_valid && (fwd_count == MAX_COUNT)) overflow <= 1'b1;
      if (hit_valid && (state != ST_ACCUM))     dropped  <= 1'b1;
    end
  end

  // Controller: command decode, drain, clear sweep and read-out sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      drain_to_read <= 1'b0;
      clr_idx       <= '0;
      rd_valid      <= 1'b0;
      rd_bin        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          case (Command)
            CMD_CLEAR: begin
              state   <= ST_CLEAR;
              clr_idx <= '0;
            end
            CMD_ACCUM: state <= ST_ACCUM;
            CMD_READ:  state <= ST_READ;
            default:   state <= ST_IDLE;
          endcase
        end
        ST_ACCUM: begin
          if ((Command == CMD_READ) || (Command == CMD_CLEAR)) begin
            state         <= ST_DRAIN;
            drain_to_read <= (Command == CMD_READ);
          end
        end
        ST_DRAIN: begin
          // S2 (if any) commits on this edge; only S1 still needs a cycle
          if (!s1_valid) begin
            if (drain_to_read) begin
              state <= ST_READ;
            end else begin
              state   <= ST_CLEAR;
              clr_idx <= '0;
            end
          end
        end
        ST_CLEAR: begin
          clr_idx <= clr_idx + BIN_AW'(1);
          if (clr_idx == LAST_BIN) state <= ST_IDLE;
        end
        ST_READ: begin
          if (!rd_valid) begin
            rd_valid <= 1'b1;
            rd_bin   <= '0;
          end else if (xfer) begin
            if (rd_bin == LAST_BIN) begin
              rd_valid <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              rd_bin <= rd_bin + BIN_AW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
